// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard unit: forward selects, FSM states
// and the default register-address width.
package hazard_pkg;

    localparam int REG_AW_DEFAULT = 3;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_IMM     = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;
    localparam logic [1:0] FWD_MEMWB   = 2'b11;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        FLUSH      = 2'd2
    } hazard_state_t;

endpackage

// File: rtl/hazard_slot_pipe.sv
// Shadow EX/MEM/WB slot shift register. The tail (valid/dest/reg_write) walks all
// three stages; the head holds operand-side fields that only the EX stage needs.
module hazard_slot_pipe
    import hazard_pkg::*;
#(
    parameter int HEAD_W = 8,
    parameter int TAIL_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bubble,
    input  logic [HEAD_W-1:0] in_head,
    input  logic [TAIL_W-1:0] in_tail,
    output logic [HEAD_W-1:0] ex_head,
    output logic [TAIL_W-1:0] ex_tail,
    output logic [TAIL_W-1:0] mem_tail,
    output logic [TAIL_W-1:0] wb_tail
);

    // Bit 0 of the tail is the valid flag; an empty slot is stored as all zeros
    // so a bubble can never match anything downstream.
    logic              drop;
    logic [HEAD_W-1:0] head_reg;
    logic [TAIL_W-1:0] feed  [3];
    logic [TAIL_W-1:0] stage [3];

    assign drop    = bubble || !in_tail[0];
    assign feed[0] = drop ? '0 : in_tail;

    always_ff @(posedge clk) begin
        if (!reset || drop) begin
            head_reg <= '0;
        end else begin
            head_reg <= in_head;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_slot
            logic [TAIL_W-1:0] slot_reg;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    slot_reg <= '0;
                end else begin
                    slot_reg <= feed[gi];
                end
            end

            assign stage[gi] = slot_reg;

            if (gi < 2) begin : g_link
                assign feed[gi+1] = slot_reg;
            end
        end
    endgenerate

    assign ex_head  = head_reg;
    assign ex_tail  = stage[0];
    assign mem_tail = stage[1];
    assign wb_tail  = stage[2];

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, taken-branch flush, EX operand forwarding
// and saturating stall/flush event counters.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src_a,
    input  logic [REG_AW-1:0] id_src_b,
    input  logic              id_use_a,
    input  logic              id_use_b,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              id_alu_b_imm,
    input  logic              ex_branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic [1:0]        forward_A,
    output logic [1:0]        forward_B,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    typedef struct packed {
        logic [REG_AW-1:0] dest;
        logic              reg_write;
        logic              valid;
    } tail_t;

    typedef struct packed {
        logic              alu_b_imm;
        logic              use_b;
        logic              use_a;
        logic [REG_AW-1:0] src_b;
        logic [REG_AW-1:0] src_a;
        logic              mem_read;
    } head_t;

    localparam int HEAD_W = $bits(head_t);
    localparam int TAIL_W = $bits(tail_t);

    head_t id_head, ex_head;
    tail_t id_tail, ex_tail, mem_tail, wb_tail;

    hazard_state_t    state_reg, state_next;
    logic [CNT_W-1:0] stall_count_reg, flush_count_reg;
    logic             load_use;
    logic             stall_event, flush_event;

    assign id_tail = {id_dest, id_reg_write, id_valid};
    assign id_head = {id_alu_b_imm, id_use_b, id_use_a, id_src_b, id_src_a, id_mem_read};

    hazard_slot_pipe #(
        .HEAD_W (HEAD_W),
        .TAIL_W (TAIL_W)
    ) u_slot_pipe (
        .clk      (clk),
        .reset    (reset),
        .bubble   (id_ex_bubble),
        .in_head  (id_head),
        .in_tail  (id_tail),
        .ex_head  (ex_head),
        .ex_tail  (ex_tail),
        .mem_tail (mem_tail),
        .wb_tail  (wb_tail)
    );

    // A slot "produces" r when it will really write r; register 0 is hardwired.
    function automatic logic produces(input tail_t s, input logic [REG_AW-1:0] r);
        return s.valid && s.reg_write && (s.dest != '0) && (s.dest == r);
    endfunction

    assign load_use = id_valid && ex_head.mem_read &&
                      ((id_use_a && produces(ex_tail, id_src_a)) ||
                       (id_use_b && produces(ex_tail, id_src_b)));

    // The cycle after a stall always has a bubble in EX, so LOAD_STALL never re-enters
    // itself; a branch always overrides the stall.
    always_comb begin
        state_next   = RUN;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        stall_event  = 1'b0;
        flush_event  = 1'b0;
        if (reset) begin
            if (ex_branch_taken) begin
                state_next   = FLUSH;
                if_id_flush  = 1'b1;
                id_ex_bubble = 1'b1;
                flush_event  = 1'b1;
            end else if (load_use && (state_reg != LOAD_STALL)) begin
                state_next   = LOAD_STALL;
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
                stall_event  = 1'b1;
            end
        end
    end

    always_comb begin
        forward_A = FWD_REGFILE;
        forward_B = FWD_REGFILE;
        if (reset) begin
            if (ex_head.use_a && produces(mem_tail, ex_head.src_a)) begin
                forward_A = FWD_EXMEM;
            end else if (ex_head.use_a && produces(wb_tail, ex_head.src_a)) begin
                forward_A = FWD_MEMWB;
            end

            if (ex_head.alu_b_imm) begin
                forward_B = FWD_IMM;
            end else if (ex_head.use_b && produces(mem_tail, ex_head.src_b)) begin
                forward_B = FWD_EXMEM;
            end else if (ex_head.use_b && produces(wb_tail, ex_head.src_b)) begin
                forward_B = FWD_MEMWB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg       <= RUN;
            stall_count_reg <= '0;
            flush_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            if (stall_event && (stall_count_reg != '1)) begin
                stall_count_reg <= stall_count_reg + CNT_W'(1);
            end
            if (flush_event && (flush_count_reg != '1)) begin
                flush_count_reg <= flush_count_reg + CNT_W'(1);
            end
        end
    end

    assign stall_count = stall_count_reg;
    assign flush_count = flush_count_reg;

endmodule

// File: tb/tb_hazard_unit.sv
// Scoreboard bench for hazard_unit: directed pipeline scenarios plus random traffic,
// checked against an instruction-level model of the EX/MEM/WB pipeline.
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [2:0] id_src_a, id_src_b, id_dest;
    logic       id_use_a, id_use_b, id_reg_write, id_mem_read, id_alu_b_imm;
    logic       ex_branch_taken;
    logic       pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic [1:0] forward_A, forward_B;
    logic [15:0] stall_count, flush_count;

    always #5 clk = ~clk;

    hazard_unit #(.REG_AW(3), .CNT_W(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid        (id_valid),
        .id_src_a        (id_src_a),
        .id_src_b        (id_src_b),
        .id_use_a        (id_use_a),
        .id_use_b        (id_use_b),
        .id_dest         (id_dest),
        .id_reg_write    (id_reg_write),
        .id_mem_read     (id_mem_read),
        .id_alu_b_imm    (id_alu_b_imm),
        .ex_branch_taken (ex_branch_taken),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .if_id_flush     (if_id_flush),
        .id_ex_bubble    (id_ex_bubble),
        .forward_A       (forward_A),
        .forward_B       (forward_B),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    typedef struct packed {
        bit       valid;
        bit [2:0] dest;
        bit       rw;
        bit       ld;
        bit [2:0] sa;
        bit       ua;
        bit [2:0] sb;
        bit       ub;
        bit       imm;
    } instr_t;

    typedef struct packed {
        bit        pc;
        bit        ifw;
        bit        fl;
        bit        bub;
        bit [1:0]  fa;
        bit [1:0]  fb;
        bit [15:0] sc;
        bit [15:0] fc;
    } exp_t;

    exp_t   exp_q[$];
    instr_t pipe_m[$];     // [0]=EX, [1]=MEM, [2]=WB, instruction view
    int     stall_m, flush_m;
    int     n_cmp = 0, n_bad = 0, cyc = 0;
    instr_t cur_i;
    bit     cur_br, cur_rst;
    bit     verbose = 1'b1;
    string  phase = "reset";
    exp_t   mon_e, mon_a;

    function automatic instr_t mk(bit v, bit [2:0] d, bit rw, bit ld,
                                  bit [2:0] sa, bit ua, bit [2:0] sb, bit ub, bit imm);
        instr_t r;
        r.valid = v; r.dest = d; r.rw = rw; r.ld = ld;
        r.sa = sa; r.ua = ua; r.sb = sb; r.ub = ub; r.imm = imm;
        return r;
    endfunction

    function automatic instr_t rnd_instr();
        instr_t r;
        r.valid = ($urandom_range(0, 9) != 0);
        r.dest  = ($urandom_range(0, 1) == 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        r.rw    = ($urandom_range(0, 4) != 0);
        r.ld    = ($urandom_range(0, 2) == 0);
        r.sa    = 3'($urandom_range(0, 3));
        r.sb    = 3'($urandom_range(0, 3));
        r.ua    = ($urandom_range(0, 3) != 0);
        r.imm   = ($urandom_range(0, 3) == 0);
        r.ub    = !r.imm && ($urandom_range(0, 3) != 0);
        return r;
    endfunction

    // Does instruction s actually deliver a new value of register r?
    function automatic bit writes(instr_t s, bit [2:0] r);
        return s.valid && s.rw && (s.dest != 3'd0) && (s.dest == r);
    endfunction

    function automatic bit reads(instr_t s, bit [2:0] r);
        return (s.ua && s.sa == r) || (s.ub && s.sb == r);
    endfunction

    function automatic bit load_use_m();
        instr_t ex = pipe_m[0];
        return cur_i.valid && ex.ld && writes(ex, ex.dest) && reads(cur_i, ex.dest);
    endfunction

    function automatic bit [1:0] fwd_sel(bit use_src, bit [2:0] src);
        if (use_src && writes(pipe_m[1], src)) return 2'b10;
        if (use_src && writes(pipe_m[2], src)) return 2'b11;
        return 2'b00;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e = '0;
        e.pc  = 1'b1;
        e.ifw = 1'b1;
        e.sc  = 16'(stall_m);
        e.fc  = 16'(flush_m);
        if (cur_rst) begin
            if (cur_br) begin
                e.fl  = 1'b1;
                e.bub = 1'b1;
            end else if (load_use_m()) begin
                e.pc  = 1'b0;
                e.ifw = 1'b0;
                e.bub = 1'b1;
            end
            e.fa = fwd_sel(pipe_m[0].ua, pipe_m[0].sa);
            e.fb = pipe_m[0].imm ? 2'b01 : fwd_sel(pipe_m[0].ub, pipe_m[0].sb);
        end
        return e;
    endfunction

    // Apply the rising edge to the model using the inputs held during the last cycle.
    task automatic advance();
        bit     stall;
        instr_t nx;
        if (!cur_rst) begin
            pipe_m  = {instr_t'(0), instr_t'(0), instr_t'(0)};
            stall_m = 0;
            flush_m = 0;
        end else begin
            stall = !cur_br && load_use_m();
            nx    = (cur_i.valid && !cur_br && !stall) ? cur_i : instr_t'(0);
            if (stall && stall_m < 65535) stall_m++;
            if (cur_br && flush_m < 65535) flush_m++;
            pipe_m.push_front(nx);
            void'(pipe_m.pop_back());
        end
    endtask

    task automatic drive(instr_t i, bit br, bit rst);
        @(posedge clk);
        #1;
        advance();
        cur_i = i; cur_br = br; cur_rst = rst;
        reset = rst;           ex_branch_taken = br;
        id_valid = i.valid;    id_dest = i.dest;
        id_reg_write = i.rw;   id_mem_read = i.ld;
        id_src_a = i.sa;       id_use_a = i.ua;
        id_src_b = i.sb;       id_use_b = i.ub;
        id_alu_b_imm = i.imm;
        exp_q.push_back(expect_now());
        cyc++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_a = {pc_write, if_id_write, if_id_flush, id_ex_bubble,
                     forward_A, forward_B, stall_count, flush_count};
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_bad++;
                $display("FAIL %s cyc %0d: got pc=%b ifw=%b fl=%b bub=%b fa=%b fb=%b sc=%0d fc=%0d required pc=%b ifw=%b fl=%b bub=%b fa=%b fb=%b sc=%0d fc=%0d",
                         phase, cyc, mon_a.pc, mon_a.ifw, mon_a.fl, mon_a.bub, mon_a.fa, mon_a.fb,
                         mon_a.sc, mon_a.fc, mon_e.pc, mon_e.ifw, mon_e.fl, mon_e.bub, mon_e.fa,
                         mon_e.fb, mon_e.sc, mon_e.fc);
            end else if (verbose) begin
                $display("%-10s cyc %0d: pc=%b ifw=%b fl=%b bub=%b fa=%b fb=%b sc=%0d fc=%0d ok",
                         phase, cyc, mon_a.pc, mon_a.ifw, mon_a.fl, mon_a.bub, mon_a.fa, mon_a.fb,
                         mon_a.sc, mon_a.fc);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        instr_t nop, lw3, add3, addi2, immb, w0, lw0, rd0;
        nop   = '0;
        lw3   = mk(1, 3'd3, 1, 1, 3'd1, 1, 3'd0, 0, 0);
        add3  = mk(1, 3'd4, 1, 0, 3'd3, 1, 3'd1, 1, 0);
        addi2 = mk(1, 3'd2, 1, 0, 3'd1, 1, 3'd0, 0, 1);
        immb  = mk(1, 3'd6, 1, 0, 3'd1, 1, 3'd2, 1, 1);
        w0    = mk(1, 3'd0, 1, 0, 3'd1, 1, 3'd1, 1, 0);
        lw0   = mk(1, 3'd0, 1, 1, 3'd1, 1, 3'd0, 0, 0);
        rd0   = mk(1, 3'd5, 1, 0, 3'd0, 1, 3'd0, 1, 0);

        pipe_m  = {instr_t'(0), instr_t'(0), instr_t'(0)};
        stall_m = 0; flush_m = 0;
        cur_i = '0; cur_br = 0; cur_rst = 0;
        reset = 0; ex_branch_taken = 0; id_valid = 0; id_dest = 0;
        id_reg_write = 0; id_mem_read = 0; id_src_a = 0; id_src_b = 0;
        id_use_a = 0; id_use_b = 0; id_alu_b_imm = 0;

        phase = "reset";
        drive(nop, 0, 0);
        drive(lw3, 1, 0);
        drive(add3, 1, 0);

        phase = "load_use";
        drive(lw3, 0, 1);
        drive(add3, 0, 1);
        drive(add3, 0, 1);
        drive(nop, 0, 1);
        drive(nop, 0, 1);

        phase = "fwd_exmem";
        drive(mk(1, 3'd2, 1, 0, 3'd1, 1, 3'd1, 1, 0), 0, 1);
        drive(mk(1, 3'd5, 1, 0, 3'd2, 1, 3'd2, 1, 0), 0, 1);
        drive(nop, 0, 1);
        drive(nop, 0, 1);

        phase = "imm_b";
        drive(addi2, 0, 1);
        drive(immb, 0, 1);
        drive(nop, 0, 1);
        drive(nop, 0, 1);

        phase = "br_vs_ld";
        drive(lw3, 0, 1);
        drive(add3, 1, 1);
        drive(nop, 0, 1);
        drive(nop, 0, 1);

        phase = "reg_zero";
        drive(w0, 0, 1);
        drive(lw0, 0, 1);
        drive(rd0, 0, 1);
        drive(rd0, 0, 1);
        drive(nop, 0, 1);

        phase = "rst_stall";
        drive(lw3, 0, 1);
        drive(add3, 0, 1);
        drive(add3, 0, 0);
        drive(add3, 0, 1);
        drive(nop, 0, 1);

        phase = "random";
        verbose = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            drive(rnd_instr(), ($urandom_range(0, 7) == 0), ($urandom_range(0, 49) != 0));
        end
        $display("random     cyc %0d: 3000 random transactions issued", cyc);

        phase = "saturate";
        drive(nop, 0, 0);
        for (int n = 0; n < 65538; n++) begin
            drive(rnd_instr(), 1, 1);
        end
        drive(nop, 0, 1);
        $display("saturate   cyc %0d: 65538 forced flushes issued", cyc);

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end

        n_cmp++;
        if (flush_count !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL flush_sat: got %h required ffff", flush_count);
        end else begin
            $display("flush_sat  cyc %0d: flush_count=%h ok", cyc, flush_count);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
